// File: rtl/subtraction.sv
// Signed-magnitude difference of two 3-digit packed BCD numbers, registered.
// Output is {sign digit, hundreds, tens, ones}; err flags any non-BCD input nibble.
module subtraction #(
    parameter logic [3:0] POS_CODE = 4'd0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  sign,
    input  logic [11:0] num,
    input  logic [11:0] sub,
    output logic [15:0] res,
    output logic        err
);

    logic [9:0]  n_bin;
    logic [9:0]  s_bin;
    logic [9:0]  diff;
    logic [3:0]  top_digit;
    logic [11:0] diff_bcd;
    logic        bad_digit;

    function automatic logic [9:0] bcd2bin(input logic [11:0] bcd);
        logic [9:0] hund;
        logic [9:0] tens;
        logic [9:0] ones;
        hund = {6'd0, bcd[11:8]};
        tens = {6'd0, bcd[7:4]};
        ones = {6'd0, bcd[3:0]};
        return hund * 10'd100 + tens * 10'd10 + ones;
    endfunction

    // Double-dabble: 10 shift steps cover the full 0..999 range.
    function automatic logic [11:0] bin2bcd(input logic [9:0] bin);
        logic [21:0] sr;
        sr = {12'd0, bin};
        for (int i = 0; i < 10; i++) begin
            if (sr[13:10] >= 4'd5) sr[13:10] = sr[13:10] + 4'd3;
            if (sr[17:14] >= 4'd5) sr[17:14] = sr[17:14] + 4'd3;
            if (sr[21:18] >= 4'd5) sr[21:18] = sr[21:18] + 4'd3;
            sr = sr << 1;
        end
        return sr[21:10];
    endfunction

    function automatic logic nibble_bad(input logic [11:0] bcd);
        return (bcd[11:8] > 4'd9) || (bcd[7:4] > 4'd9) || (bcd[3:0] > 4'd9);
    endfunction

    always_comb begin
        n_bin     = bcd2bin(num);
        s_bin     = bcd2bin(sub);
        bad_digit = nibble_bad(num) || nibble_bad(sub);
        // Zero difference takes the non-negative branch.
        if (n_bin >= s_bin) begin
            diff      = n_bin - s_bin;
            top_digit = POS_CODE;
        end else begin
            diff      = s_bin - n_bin;
            top_digit = sign;
        end
        diff_bcd = bin2bcd(diff);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res <= 16'h0000;
            err <= 1'b0;
        end else if (bad_digit) begin
            res <= 16'h0000;
            err <= 1'b1;
        end else begin
            res <= {top_digit, diff_bcd};
            err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_subtraction.sv
// Directed and sweep checks for the BCD subtractor, including async reset behaviour.
module tb_subtraction;

    logic        clk;
    logic        rst_n;
    logic [3:0]  sign;
    logic [11:0] num;
    logic [11:0] sub;
    logic [15:0] res;
    logic        err;

    int total = 0;
    int bad   = 0;

    subtraction dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sign  (sign),
        .num   (num),
        .sub   (sub),
        .res   (res),
        .err   (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [16:0] got, input logic [16:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got err=%0b res=%04h, expected err=%0b res=%04h",
                     tag, got[16], got[15:0], exp[16], exp[15:0]);
        end
    endtask

    typedef struct {
        logic [11:0] n;
        logic [11:0] s;
        logic [3:0]  sg;
        logic [15:0] r;
        logic        e;
    } vec_t;

    vec_t vecs[$];

    task automatic apply(input logic [11:0] n, input logic [11:0] s, input logic [3:0] sg);
        @(negedge clk);
        num  = n;
        sub  = s;
        sign = sg;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs.push_back('{12'h255, 12'h099, 4'hA, 16'h0156, 1'b0});
        vecs.push_back('{12'h050, 12'h099, 4'hA, 16'hA049, 1'b0});
        vecs.push_back('{12'h099, 12'h099, 4'hA, 16'h0000, 1'b0});
        vecs.push_back('{12'h000, 12'h999, 4'hA, 16'hA999, 1'b0});
        vecs.push_back('{12'h999, 12'h000, 4'hA, 16'h0999, 1'b0});
        vecs.push_back('{12'h0A0, 12'h099, 4'hA, 16'h0000, 1'b1});
        vecs.push_back('{12'h123, 12'h045, 4'hA, 16'h0078, 1'b0});
        vecs.push_back('{12'h001, 12'h002, 4'hF, 16'hF001, 1'b0});
        vecs.push_back('{12'h500, 12'h499, 4'hA, 16'h0001, 1'b0});
        vecs.push_back('{12'h00F, 12'h000, 4'hA, 16'h0000, 1'b1});
        vecs.push_back('{12'h000, 12'hB00, 4'hA, 16'h0000, 1'b1});
        vecs.push_back('{12'h999, 12'h999, 4'h3, 16'h0000, 1'b0});
        vecs.push_back('{12'h100, 12'h001, 4'hA, 16'h0099, 1'b0});
        vecs.push_back('{12'h010, 12'h100, 4'h7, 16'h7090, 1'b0});
        vecs.push_back('{12'h909, 12'h090, 4'hA, 16'h0819, 1'b0});

        rst_n = 1'b0;
        num   = 12'h255;
        sub   = 12'h099;
        sign  = 4'hA;

        // Held in reset across clock edges with valid inputs present.
        repeat (3) @(posedge clk);
        #1;
        chk("reset_hold", {err, res}, 17'h0_0000);

        // First edge after release loads the inputs present at that edge.
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("first_edge", {err, res}, {1'b0, 16'h0156});

        foreach (vecs[i]) begin
            apply(vecs[i].n, vecs[i].s, vecs[i].sg);
            chk($sformatf("vec%0d", i), {err, res}, {vecs[i].e, vecs[i].r});
        end

        // Sweep: minuend 0..255 in BCD against a fixed subtrahend of 99.
        for (int k = 0; k < 20000; k++) begin
            int          n;
            int          d;
            logic [3:0]  code;
            logic [11:0] nb;
            logic [15:0] exp_r;
            n  = $urandom_range(0, 255);
            nb = {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
            if (n >= 99) begin
                d    = n - 99;
                code = 4'h0;
            end else begin
                d    = 99 - n;
                code = 4'hA;
            end
            exp_r = {code, 4'(d / 100), 4'((d / 10) % 10), 4'(d % 10)};
            apply(nb, 12'h099, 4'hA);
            if (k % 1000 == 0)
                chk($sformatf("sweep%0d", k), {err, res}, {1'b0, exp_r});
            else if ({err, res} !== {1'b0, exp_r})
                chk($sformatf("sweep%0d", k), {err, res}, {1'b0, exp_r});

            if (k == 10000) begin
                apply(12'h255, 12'h099, 4'hA);
                chk("pre_rst", {err, res}, {1'b0, 16'h0156});
                rst_n = 1'b0;
                #1;
                chk("async_rst", {err, res}, 17'h0_0000);
                @(posedge clk);
                #1;
                chk("rst_held", {err, res}, 17'h0_0000);
                @(negedge clk);
                rst_n = 1'b1;
                @(posedge clk);
                #1;
                chk("rst_release", {err, res}, {1'b0, 16'h0156});
            end
        end

        // Error recovery on the very next edge.
        apply(12'h0A0, 12'h099, 4'hA);
        chk("err_set", {err, res}, {1'b1, 16'h0000});
        apply(12'h255, 12'h099, 4'hA);
        chk("err_clear", {err, res}, {1'b0, 16'h0156});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
